// File: rtl/inst_decode_pipe.sv
// Instruction buffer (power-of-2 FIFO) feeding a registered decode stage.
// Decoded fields are held while the consumer stalls; flush/reset drop everything in flight.
module inst_decode_pipe #(
  parameter int DEPTH    = 4,
  parameter bit IMM_SEXT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              inst,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               opcode,
  output logic [4:0]               rsAddr,
  output logic [4:0]               rtAddr,
  output logic [4:0]               shamt,
  output logic [3:0]               fcode,
  output logic [31:0]              imm,
  output logic [24:0]              label,
  output logic                     mem_write,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [3:0]  fcode;
    logic [31:0] imm;
    logic [24:0] label;
    logic        mem_write;
    logic        illegal;
  } dec_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, load;
  logic [31:0]   head;
  dec_t          d, q;

  // Depends on occupancy only, so the producer never waits on the consumer.
  assign in_ready = count < FULL;
  assign push     = in_valid && in_ready;
  assign load     = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  always_comb begin
    d        = '0;
    d.opcode = head[31:29];
    case (head[31:29])
      3'd0: begin
        d.rs    = head[28:24];
        d.rt    = head[23:19];
        d.shamt = head[18:14];
        d.fcode = head[13:10];
      end
      3'd1: begin
        d.rs    = head[28:24];
        d.fcode = {2'b00, head[1:0]};
        d.imm   = IMM_SEXT ? {{10{head[23]}}, head[23:2]} : {10'b0, head[23:2]};
      end
      3'd2: begin
        d.rs        = head[28:24];
        d.rt        = head[23:19];
        d.fcode     = {3'b000, head[0]};
        d.imm       = IMM_SEXT ? {{14{head[18]}}, head[18:1]} : {14'b0, head[18:1]};
        d.mem_write = head[0];
      end
      3'd3: begin
        d.label = head[28:4];
        d.fcode = head[3:0];
      end
      3'd4: d.rs = head[28:24];
      default: d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) begin
        rd_ptr <= rd_ptr + PW'(1);
        q      <= d;
      end
      if (load)           out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      case ({push, load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= inst;
  end

  assign opcode    = q.opcode;
  assign rsAddr    = q.rs;
  assign rtAddr    = q.rt;
  assign shamt     = q.shamt;
  assign fcode     = q.fcode;
  assign imm       = q.imm;
  assign label     = q.label;
  assign mem_write = q.mem_write;
  assign illegal   = q.illegal;
endmodule

// File: tb/tb_inst_decode_pipe.sv
// Scoreboard bench: two DUTs (zero- and sign-extending imm) share one stimulus stream;
// expected decodes are queued on acceptance and popped by a monitor on each handshake.
module tb_inst_decode_pipe;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;

  logic          in_ready, out_valid, mem_write, illegal;
  logic [2:0]    opcode;
  logic [4:0]    rsAddr, rtAddr, shamt;
  logic [3:0]    fcode;
  logic [31:0]   imm;
  logic [24:0]   label;
  logic [CW-1:0] count;

  logic          s_in_ready, s_out_valid, s_mem_write, s_illegal;
  logic [2:0]    s_opcode;
  logic [4:0]    s_rsAddr, s_rtAddr, s_shamt;
  logic [3:0]    s_fcode;
  logic [31:0]   s_imm;
  logic [24:0]   s_label;
  logic [CW-1:0] s_count;

  always #5 clk = ~clk;

  inst_decode_pipe #(.DEPTH(DEPTH), .IMM_SEXT(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .inst(inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rsAddr(rsAddr), .rtAddr(rtAddr), .shamt(shamt), .fcode(fcode),
    .imm(imm), .label(label), .mem_write(mem_write), .illegal(illegal), .count(count));

  inst_decode_pipe #(.DEPTH(DEPTH), .IMM_SEXT(1'b1)) dut_sext (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .inst(inst),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
    .opcode(s_opcode), .rsAddr(s_rsAddr), .rtAddr(s_rtAddr), .shamt(s_shamt), .fcode(s_fcode),
    .imm(s_imm), .label(s_label), .mem_write(s_mem_write), .illegal(s_illegal), .count(s_count));

  typedef struct {
    logic [31:0] w;
    logic [2:0]  op;
    logic [4:0]  rs, rt, sh;
    logic [3:0]  fc;
    logic [31:0] imm0, imm1;
    logic [24:0] lab;
    logic        mw, il;
  } exp_t;

  exp_t q[$];
  exp_t vec[8];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(logic [31:0] w, logic [2:0] op, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] sh, logic [3:0] fc, logic [31:0] imm0,
                              logic [31:0] imm1, logic [24:0] lab, logic mw, logic il);
    exp_t e;
    e.w = w; e.op = op; e.rs = rs; e.rt = rt; e.sh = sh; e.fc = fc;
    e.imm0 = imm0; e.imm1 = imm1; e.lab = lab; e.mw = mw; e.il = il;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a consume happens at the next edge when valid && ready (flush/reset win).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=opcode %0d expected=no output t=%0t", opcode, $time);
        end else begin
          e = q.pop_front();
          chk("opcode",    32'(opcode),    32'(e.op));
          chk("rsAddr",    32'(rsAddr),    32'(e.rs));
          chk("rtAddr",    32'(rtAddr),    32'(e.rt));
          chk("shamt",     32'(shamt),     32'(e.sh));
          chk("fcode",     32'(fcode),     32'(e.fc));
          chk("imm_zext",  imm,            e.imm0);
          chk("label",     32'(label),     32'(e.lab));
          chk("mem_write", 32'(mem_write), 32'(e.mw));
          chk("illegal",   32'(illegal),   32'(e.il));
          chk("imm_sext",  s_imm,          e.imm1);
          chk("sext_valid", 32'(s_out_valid), 32'd1);
        end
      end
    end
  end

  // Offer one word for one cycle; starts and ends just after a rising edge.
  task automatic push(exp_t e);
    in_valid = 1'b1;
    inst     = e.w;
    @(negedge clk);
    if (in_ready) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec[0] = mk(32'h0A2C4C00, 3'd0, 5'd10, 5'd5,  5'd17, 4'd3,  32'h0, 32'h0, 25'h0, 1'b0, 1'b0);
    vec[1] = mk(32'h3FFFFFFD, 3'd1, 5'd31, 5'd0,  5'd0,  4'd1,  32'h003FFFFF, 32'hFFFFFFFF, 25'h0, 1'b0, 1'b0);
    // inst[18] is set here, so the 18-bit field is 0x20001
    vec[2] = mk(32'h4A0C0003, 3'd2, 5'd10, 5'd1,  5'd0,  4'd1,  32'h00020001, 32'hFFFE0001, 25'h0, 1'b1, 1'b0);
    vec[3] = mk(32'hE0000000, 3'd7, 5'd0,  5'd0,  5'd0,  4'd0,  32'h0, 32'h0, 25'h0, 1'b0, 1'b1);
    vec[4] = mk(32'h6123456A, 3'd3, 5'd0,  5'd0,  5'd0,  4'hA,  32'h0, 32'h0, 25'h0123456, 1'b0, 1'b0);
    vec[5] = mk(32'h9FFFFFFF, 3'd4, 5'd31, 5'd0,  5'd0,  4'd0,  32'h0, 32'h0, 25'h0, 1'b0, 1'b0);
    vec[6] = mk(32'h2100000A, 3'd1, 5'd1,  5'd0,  5'd0,  4'd2,  32'h2, 32'h2, 25'h0, 1'b0, 1'b0);
    vec[7] = mk(32'h5FFFFFFE, 3'd2, 5'd31, 5'd31, 5'd0,  4'd0,  32'h0003FFFF, 32'hFFFFFFFF, 25'h0, 1'b0, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_imm",       imm,            32'd0);

    // two-edge latency into an empty pipe
    out_ready = 1'b1;
    push(vec[0]);
    chk("lat_edge1_count", 32'(count),     32'd1);
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    drain();

    // back-to-back stream of every opcode class
    for (int i = 1; i < 8; i++) push(vec[i]);
    drain();

    // stalled consumer: fill, hold, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push(vec[(i + 1) % 8]);
    chk("full_count",    32'(count),    32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_queued",   32'(q.size()), 32'(DEPTH + 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid",  32'(out_valid), 32'd1);
      chk("hold_opcode", 32'(opcode),    32'(q[0].op));
      chk("hold_imm",    imm,            q[0].imm0);
      chk("hold_rs",     32'(rsAddr),    32'(q[0].rs));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // flush on a full pipe with a simultaneous push and consume
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push(vec[i]);
    chk("preflush_count", 32'(count), 32'(DEPTH));
    flush = 1'b1; in_valid = 1'b1; inst = vec[7].w; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    chk("flush_count",     32'(count),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    repeat (3) @(posedge clk);
    #1 chk("flush_dropped", 32'(out_valid | (count != 0)), 32'd0);

    // reset mid-stream
    out_ready = 1'b0;
    push(vec[1]); push(vec[2]); push(vec[4]);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_count",  32'(count),     32'd0);
    chk("mid_rst_opcode", 32'(opcode),    32'd0);
    chk("mid_rst_imm",    imm,            32'd0);
    chk("mid_rst_rs",     32'(rsAddr),    32'd0);
    chk("mid_rst_fcode",  32'(fcode),     32'd0);
    chk("mid_rst_mw",     32'(mem_write), 32'd0);
    chk("mid_rst_simm",   s_imm,          32'd0);
    rst = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // pipe works again after reset
    out_ready = 1'b1;
    push(vec[3]); push(vec[2]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
